// File: rtl/reg_file_3r1w.sv
// reg_file_3r1w
// Architectural register file between decode and execute: three read ports
// addressed by decode, one write port driven by writeback. Read data is
// registered into the execute stage (1-cycle latency).
// Special registers:
//   - PC (PC_REG_NUM) has no storage. It reads as pc_i + 4. A write to it
//     becomes a one-cycle branch request on pc_wr_o / pc_wr_data_o.
//   - SP (SP_REG_NUM) is always stored word-aligned. It resets to SP_RESET_VAL.
// Ports:
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   stall_i        hold registered read outputs (writes still happen)
//   flush_i        zero registered read outputs (overrides stall)
//   pc_i           address of the instruction in decode
//   rd_addr_N_i    read addresses, N = 1..3
//   rd_data_N_o    registered read data, N = 1..3
//   wr_en_i        writeback enable
//   wr_addr_i      writeback destination
//   wr_data_i      writeback data
//   pc_wr_o        registered pulse: PC was written last cycle
//   pc_wr_data_o   branch target with bit 0 cleared; holds between pulses
module reg_file_3r1w #(
  parameter int                   ADDR_WIDTH   = 4,
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   SP_REG_NUM   = 13,
  parameter int                   PC_REG_NUM   = 15,
  parameter logic [DATA_WIDTH-1:0] SP_RESET_VAL = 32'h0000_2000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_3_i,
  output logic [DATA_WIDTH-1:0] rd_data_1_o,
  output logic [DATA_WIDTH-1:0] rd_data_2_o,
  output logic [DATA_WIDTH-1:0] rd_data_3_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  pc_wr_o,
  output logic [DATA_WIDTH-1:0] pc_wr_data_o
);

  localparam int                  NUM_REGS = 1 << ADDR_WIDTH;
  localparam int                  NUM_RD   = 3;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(SP_REG_NUM);

  // Value that a write stores (and that a same-cycle read is bypassed).
  // SP alignment is applied here so stored and bypassed values agree.
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  pc_wr_hit;
  logic [DATA_WIDTH-1:0] pc_plus4;

  assign wr_val    = (wr_addr_i == SP_ADDR) ? {wr_data_i[DATA_WIDTH-1:2], 2'b00}
                                            : wr_data_i;
  assign pc_wr_hit = wr_en_i && (wr_addr_i == PC_ADDR);
  assign pc_plus4  = pc_i + DATA_WIDTH'(4);

  // Flat view of every architectural index. The PC slot is tied to zero;
  // it is never selected because PC reads are intercepted.
  logic [DATA_WIDTH-1:0] reg_vals [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == PC_REG_NUM) begin : g_pc
        assign reg_vals[gi] = '0;
      end else begin : g_store
        logic [DATA_WIDTH-1:0] reg_q;
        always_ff @(posedge clk_i) begin
          if (!rst_n_i) begin
            reg_q <= (gi == SP_REG_NUM) ? SP_RESET_VAL : '0;
          end else if (wr_en_i && (wr_addr_i == ADDR_WIDTH'(gi))) begin
            reg_q <= wr_val;
          end
        end
        assign reg_vals[gi] = reg_q;
      end
    end
  endgenerate

  // Read ports
  logic [ADDR_WIDTH-1:0] rd_addr   [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data_d [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data_q [NUM_RD];

  assign rd_addr[0] = rd_addr_1_i;
  assign rd_addr[1] = rd_addr_2_i;
  assign rd_addr[2] = rd_addr_3_i;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      // PC is checked first so a write to PC is never bypassed into a read.
      always_comb begin
        rd_data_d[gi] = reg_vals[rd_addr[gi]];
        if (rd_addr[gi] == PC_ADDR) begin
          rd_data_d[gi] = pc_plus4;
        end else if (wr_en_i && (rd_addr[gi] == wr_addr_i)) begin
          rd_data_d[gi] = wr_val;
        end
      end
    end
  endgenerate

  // Priority: reset > flush > stall > capture.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_RD; p++) begin
      if (!rst_n_i || flush_i) begin
        rd_data_q[p] <= '0;
      end else if (!stall_i) begin
        rd_data_q[p] <= rd_data_d[p];
      end
    end
  end

  assign rd_data_1_o = rd_data_q[0];
  assign rd_data_2_o = rd_data_q[1];
  assign rd_data_3_o = rd_data_q[2];

  // Branch request on PC write. The stall does not block it.
  logic                  pc_wr_q;
  logic [DATA_WIDTH-1:0] pc_wr_data_q;
  logic [DATA_WIDTH-1:0] pc_wr_data_d;

  assign pc_wr_data_d = pc_wr_hit ? {wr_data_i[DATA_WIDTH-1:1], 1'b0} : pc_wr_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_wr_q      <= 1'b0;
      pc_wr_data_q <= '0;
    end else begin
      pc_wr_q      <= pc_wr_hit;
      pc_wr_data_q <= pc_wr_data_d;
    end
  end

  assign pc_wr_o      = pc_wr_q;
  assign pc_wr_data_o = pc_wr_data_q;

endmodule

// File: tb/tb_reg_file_3r1w.sv
module tb_reg_file_3r1w;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [3:0]  rd_addr_1_i = '0;
  logic [3:0]  rd_addr_2_i = '0;
  logic [3:0]  rd_addr_3_i = '0;
  logic [31:0] rd_data_1_o;
  logic [31:0] rd_data_2_o;
  logic [31:0] rd_data_3_o;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        pc_wr_o;
  logic [31:0] pc_wr_data_o;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  reg_file_3r1w dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .pc_i         (pc_i),
    .rd_addr_1_i  (rd_addr_1_i),
    .rd_addr_2_i  (rd_addr_2_i),
    .rd_addr_3_i  (rd_addr_3_i),
    .rd_data_1_o  (rd_data_1_o),
    .rd_data_2_o  (rd_data_2_o),
    .rd_data_3_o  (rd_data_3_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .pc_wr_o      (pc_wr_o),
    .pc_wr_data_o (pc_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cycle++;
    $display("cycle %0d: rst_n=%b wr=%b a=%0d d=%h rd=%h %h %h pc_wr=%b pc_tgt=%h",
             cycle, rst_n_i, wr_en_i, wr_addr_i, wr_data_i,
             rd_data_1_o, rd_data_2_o, rd_data_3_o, pc_wr_o, pc_wr_data_o);
  endtask

  task automatic set_rd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
    rd_addr_1_i = a1;
    rd_addr_2_i = a2;
    rd_addr_3_i = a3;
  endtask

  task automatic set_wr(input logic en, input logic [3:0] a, input logic [31:0] d);
    wr_en_i   = en;
    wr_addr_i = a;
    wr_data_i = d;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    set_wr(1'b1, 4'd3, 32'h0000_AAAA);
    set_rd(4'd0, 4'd0, 4'd0);
    tick();
    total++; if (rd_data_1_o !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=%h", rd_data_1_o, 32'h0); end
    total++; if (rd_data_2_o !== 32'h0) begin bad++; $display("FAIL reset_rd2 got=%h exp=%h", rd_data_2_o, 32'h0); end
    total++; if (rd_data_3_o !== 32'h0) begin bad++; $display("FAIL reset_rd3 got=%h exp=%h", rd_data_3_o, 32'h0); end
    total++; if (pc_wr_o !== 1'b0) begin bad++; $display("FAIL reset_pc_wr got=%b exp=0", pc_wr_o); end
    total++; if (pc_wr_data_o !== 32'h0) begin bad++; $display("FAIL reset_pc_tgt got=%h exp=%h", pc_wr_data_o, 32'h0); end
    rst_n_i = 1'b1;
    set_wr(1'b0, 4'd0, 32'h0);
    pc_i = 32'h0;
    set_rd(4'd13, 4'd3, 4'd15);
    tick();
    total++; if (rd_data_1_o !== 32'h0000_2000) begin bad++; $display("FAIL reset_sp got=%h exp=%h", rd_data_1_o, 32'h0000_2000); end
    total++; if (rd_data_2_o !== 32'h0) begin bad++; $display("FAIL reset_r3_discard got=%h exp=%h", rd_data_2_o, 32'h0); end
    total++; if (rd_data_3_o !== 32'h4) begin bad++; $display("FAIL reset_pc_read got=%h exp=%h", rd_data_3_o, 32'h4); end
    total++; if (pc_wr_o !== 1'b0) begin bad++; $display("FAIL reset_pc_wr_after got=%b exp=0", pc_wr_o); end
  endtask

  task automatic test_write_read();
    set_wr(1'b1, 4'd5, 32'h1234_5678);
    set_rd(4'd0, 4'd0, 4'd0);
    tick();
    total++; if (rd_data_1_o !== 32'h0) begin bad++; $display("FAIL wr_r0_before got=%h exp=%h", rd_data_1_o, 32'h0); end
    set_wr(1'b0, 4'd0, 32'h0);
    set_rd(4'd5, 4'd0, 4'd13);
    tick();
    total++; if (rd_data_1_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_r5 got=%h exp=%h", rd_data_1_o, 32'h1234_5678); end
    total++; if (rd_data_2_o !== 32'h0) begin bad++; $display("FAIL rd_r0 got=%h exp=%h", rd_data_2_o, 32'h0); end
    total++; if (rd_data_3_o !== 32'h0000_2000) begin bad++; $display("FAIL rd_sp got=%h exp=%h", rd_data_3_o, 32'h0000_2000); end
  endtask

  task automatic test_bypass();
    set_wr(1'b1, 4'd2, 32'hDEAD_BEEF);
    set_rd(4'd2, 4'd2, 4'd2);
    tick();
    total++; if (rd_data_1_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_r2_p1 got=%h exp=%h", rd_data_1_o, 32'hDEAD_BEEF); end
    total++; if (rd_data_2_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_r2_p2 got=%h exp=%h", rd_data_2_o, 32'hDEAD_BEEF); end
    total++; if (rd_data_3_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_r2_p3 got=%h exp=%h", rd_data_3_o, 32'hDEAD_BEEF); end
    set_wr(1'b1, 4'd0, 32'hCAFE_F00D);
    set_rd(4'd0, 4'd0, 4'd0);
    tick();
    total++; if (rd_data_1_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_r0_p1 got=%h exp=%h", rd_data_1_o, 32'hCAFE_F00D); end
    total++; if (rd_data_2_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_r0_p2 got=%h exp=%h", rd_data_2_o, 32'hCAFE_F00D); end
    total++; if (rd_data_3_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_r0_p3 got=%h exp=%h", rd_data_3_o, 32'hCAFE_F00D); end
    set_wr(1'b0, 4'd0, 32'h0);
    set_rd(4'd2, 4'd0, 4'd5);
    tick();
    total++; if (rd_data_1_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stored_r2 got=%h exp=%h", rd_data_1_o, 32'hDEAD_BEEF); end
    total++; if (rd_data_2_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL stored_r0 got=%h exp=%h", rd_data_2_o, 32'hCAFE_F00D); end
    total++; if (rd_data_3_o !== 32'h1234_5678) begin bad++; $display("FAIL stored_r5 got=%h exp=%h", rd_data_3_o, 32'h1234_5678); end
  endtask

  task automatic test_pc_read();
    pc_i = 32'h0000_0100;
    set_rd(4'd15, 4'd0, 4'd2);
    tick();
    total++; if (rd_data_1_o !== 32'h0000_0104) begin bad++; $display("FAIL pc_read got=%h exp=%h", rd_data_1_o, 32'h0000_0104); end
    pc_i = 32'hFFFF_FFFE;
    set_rd(4'd15, 4'd15, 4'd15);
    tick();
    total++; if (rd_data_1_o !== 32'h0000_0002) begin bad++; $display("FAIL pc_wrap_p1 got=%h exp=%h", rd_data_1_o, 32'h0000_0002); end
    total++; if (rd_data_2_o !== 32'h0000_0002) begin bad++; $display("FAIL pc_wrap_p2 got=%h exp=%h", rd_data_2_o, 32'h0000_0002); end
    total++; if (rd_data_3_o !== 32'h0000_0002) begin bad++; $display("FAIL pc_wrap_p3 got=%h exp=%h", rd_data_3_o, 32'h0000_0002); end
  endtask

  task automatic test_sp_align();
    set_wr(1'b1, 4'd13, 32'h0000_1FFF);
    set_rd(4'd13, 4'd0, 4'd0);
    tick();
    total++; if (rd_data_1_o !== 32'h0000_1FFC) begin bad++; $display("FAIL sp_bypass got=%h exp=%h", rd_data_1_o, 32'h0000_1FFC); end
    set_wr(1'b0, 4'd0, 32'h0);
    set_rd(4'd0, 4'd13, 4'd0);
    tick();
    total++; if (rd_data_2_o !== 32'h0000_1FFC) begin bad++; $display("FAIL sp_stored got=%h exp=%h", rd_data_2_o, 32'h0000_1FFC); end
  endtask

  task automatic test_pc_write();
    pc_i = 32'h0000_0300;
    set_wr(1'b1, 4'd15, 32'h0000_0201);
    set_rd(4'd15, 4'd0, 4'd0);
    tick();
    total++; if (pc_wr_o !== 1'b1) begin bad++; $display("FAIL pc_wr_pulse got=%b exp=1", pc_wr_o); end
    total++; if (pc_wr_data_o !== 32'h0000_0200) begin bad++; $display("FAIL pc_wr_tgt got=%h exp=%h", pc_wr_data_o, 32'h0000_0200); end
    total++; if (rd_data_1_o !== 32'h0000_0304) begin bad++; $display("FAIL pc_no_bypass got=%h exp=%h", rd_data_1_o, 32'h0000_0304); end
    set_wr(1'b0, 4'd0, 32'h0);
    tick();
    total++; if (pc_wr_o !== 1'b0) begin bad++; $display("FAIL pc_wr_drop got=%b exp=0", pc_wr_o); end
    total++; if (pc_wr_data_o !== 32'h0000_0200) begin bad++; $display("FAIL pc_tgt_hold got=%h exp=%h", pc_wr_data_o, 32'h0000_0200); end
    total++; if (rd_data_1_o !== 32'h0000_0304) begin bad++; $display("FAIL pc_read_after got=%h exp=%h", rd_data_1_o, 32'h0000_0304); end
  endtask

  task automatic test_stall_flush();
    set_wr(1'b1, 4'd7, 32'h0000_0011);
    set_rd(4'd7, 4'd7, 4'd7);
    tick();
    total++; if (rd_data_1_o !== 32'h11) begin bad++; $display("FAIL pre_stall got=%h exp=%h", rd_data_1_o, 32'h11); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rd(4'd5, 4'd2, 4'd15);
      if (i == 1) set_wr(1'b1, 4'd1, 32'h0000_0055);
      else if (i == 2) set_wr(1'b1, 4'd15, 32'h0000_0401);
      else set_wr(1'b0, 4'd0, 32'h0);
      tick();
      total++; if (rd_data_1_o !== 32'h11) begin bad++; $display("FAIL stall_p1_c%0d got=%h exp=%h", i, rd_data_1_o, 32'h11); end
      total++; if (rd_data_2_o !== 32'h11) begin bad++; $display("FAIL stall_p2_c%0d got=%h exp=%h", i, rd_data_2_o, 32'h11); end
      total++; if (rd_data_3_o !== 32'h11) begin bad++; $display("FAIL stall_p3_c%0d got=%h exp=%h", i, rd_data_3_o, 32'h11); end
    end
    total++; if (pc_wr_o !== 1'b1) begin bad++; $display("FAIL stall_pc_wr got=%b exp=1", pc_wr_o); end
    total++; if (pc_wr_data_o !== 32'h0000_0400) begin bad++; $display("FAIL stall_pc_tgt got=%h exp=%h", pc_wr_data_o, 32'h0000_0400); end
    stall_i = 1'b0;
    set_wr(1'b0, 4'd0, 32'h0);
    set_rd(4'd1, 4'd2, 4'd13);
    tick();
    total++; if (rd_data_1_o !== 32'h55) begin bad++; $display("FAIL post_stall_r1 got=%h exp=%h", rd_data_1_o, 32'h55); end
    total++; if (rd_data_2_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL post_stall_r2 got=%h exp=%h", rd_data_2_o, 32'hDEAD_BEEF); end
    total++; if (rd_data_3_o !== 32'h0000_1FFC) begin bad++; $display("FAIL post_stall_sp got=%h exp=%h", rd_data_3_o, 32'h0000_1FFC); end
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick();
    total++; if (rd_data_1_o !== 32'h0) begin bad++; $display("FAIL flush_p1 got=%h exp=%h", rd_data_1_o, 32'h0); end
    total++; if (rd_data_2_o !== 32'h0) begin bad++; $display("FAIL flush_p2 got=%h exp=%h", rd_data_2_o, 32'h0); end
    total++; if (rd_data_3_o !== 32'h0) begin bad++; $display("FAIL flush_p3 got=%h exp=%h", rd_data_3_o, 32'h0); end
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_rd(4'd1, 4'd2, 4'd7);
    tick();
    total++; if (rd_data_1_o !== 32'h55) begin bad++; $display("FAIL pre_rst_r1 got=%h exp=%h", rd_data_1_o, 32'h55); end
    rst_n_i = 1'b0;
    stall_i = 1'b1;
    set_wr(1'b1, 4'd4, 32'h0000_0099);
    tick();
    total++; if (rd_data_1_o !== 32'h0) begin bad++; $display("FAIL mid_rst_out got=%h exp=%h", rd_data_1_o, 32'h0); end
    total++; if (pc_wr_data_o !== 32'h0) begin bad++; $display("FAIL mid_rst_tgt got=%h exp=%h", pc_wr_data_o, 32'h0); end
    rst_n_i = 1'b1;
    stall_i = 1'b0;
    set_wr(1'b0, 4'd0, 32'h0);
    set_rd(4'd4, 4'd13, 4'd1);
    tick();
    total++; if (rd_data_1_o !== 32'h0) begin bad++; $display("FAIL mid_rst_r4 got=%h exp=%h", rd_data_1_o, 32'h0); end
    total++; if (rd_data_2_o !== 32'h0000_2000) begin bad++; $display("FAIL mid_rst_sp got=%h exp=%h", rd_data_2_o, 32'h0000_2000); end
    total++; if (rd_data_3_o !== 32'h0) begin bad++; $display("FAIL mid_rst_r1 got=%h exp=%h", rd_data_3_o, 32'h0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_pc_read();
    test_sp_align();
    test_pc_write();
    test_stall_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
